alu_iter_seq: RTL and testbench

//  Multi-cycle sequencer that performs MUL/MULHU/DIVU/REMU using the shared single-cycle ALU for its add/subtract.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_iter_seq.sv | 150 +++++++++++++++
 tb/tb_alu_iter_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, iterative-sequencer request codes and FSM state encoding.
package alu_pkg;

   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_SUB = 5'd1;

   localparam logic [1:0] OP_MUL   = 2'd0;
   localparam logic [1:0] OP_MULHU = 2'd1;
   localparam logic [1:0] OP_DIVU  = 2'd2;
   localparam logic [1:0] OP_REMU  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_iter_seq.sv
// Iterative MUL/MULHU/DIVU/REMU sequencer borrowing the parent's ALU for add/subtract.
// Optional ALU_ITER_EARLY_OUT_EN: trivial operands skip the iteration phase.
module alu_iter_seq
   import alu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [1:0]   req_op,
   input  logic [N-1:0] req_a,
   input  logic [N-1:0] req_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_data,
   output logic         alu_own,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [4:0]   alu_op,
   input  logic [N-1:0] alu_c
);

   localparam int CNT_W = $clog2(N);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_op;
   logic [N-1:0]     r_opd;   // multiplicand or divisor
   logic [N-1:0]     r_hi;
   logic [N-1:0]     r_lo;    // multiplier/low product, or quotient
   logic [N-1:0]     r_rem;

   logic             w_is_div;
   logic             w_req_div;
   logic [N:0]       w_t;
   logic             w_sub_ok;
   logic             w_carry;
   logic             w_early;
   logic             w_accept;

   assign w_is_div  = (r_op == OP_DIVU) || (r_op == OP_REMU);
   assign w_req_div = (req_op == OP_DIVU) || (req_op == OP_REMU);
   assign w_t       = {r_rem, r_lo[N-1]};
   assign w_sub_ok  = (w_t >= {1'b0, r_opd});
   // An unsigned add wrapped exactly when the sum is below either addend.
   assign w_carry   = (alu_c < r_opd);
   assign w_accept  = (r_state == ST_IDLE) && req_valid;

`ifdef ALU_ITER_EARLY_OUT_EN
   assign w_early = w_req_div ? ((req_b != '0) && (req_a < req_b))
                              : ((req_a == '0) || (req_b == '0));
`else
   assign w_early = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept)
            r_cnt <= '0;
         else if (r_state == ST_ITER)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      alu_own     = 1'b0;
      alu_a       = '0;
      alu_b       = '0;
      alu_op      = ALU_ADD;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               w_state_nxt = w_early ? ST_DONE : ST_ITER;
         end
         ST_ITER: begin
            alu_own = 1'b1;
            if (w_is_div) begin
               if (w_sub_ok) begin
                  alu_a  = w_t[N-1:0];
                  alu_b  = r_opd;
                  alu_op = ALU_SUB;
               end
            end else if (r_lo[0]) begin
               alu_a = r_hi;
               alu_b = r_opd;
            end
            if (r_cnt == CNT_W'(N - 1))
               w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Operand/accumulator registers carry no reset; the FSM gates their visibility.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_op  <= req_op;
         r_hi  <= '0;
         if (w_req_div) begin
            r_opd <= req_b;
            r_lo  <= w_early ? '0 : req_a;
            r_rem <= w_early ? req_a : '0;
         end else begin
            r_opd <= req_a;
            r_lo  <= w_early ? '0 : req_b;
            r_rem <= '0;
         end
      end else if (r_state == ST_ITER) begin
         if (w_is_div) begin
            r_rem <= w_sub_ok ? alu_c : w_t[N-1:0];
            r_lo  <= {r_lo[N-2:0], w_sub_ok};
         end else if (r_lo[0]) begin
            r_hi <= {w_carry, alu_c[N-1:1]};
            r_lo <= {alu_c[0], r_lo[N-1:1]};
         end else begin
            r_hi <= {1'b0, r_hi[N-1:1]};
            r_lo <= {r_hi[0], r_lo[N-1:1]};
         end
      end
   end

   always_comb begin
      rsp_data = '0;
      if (r_state == ST_DONE) begin
         case (r_op)
            OP_MUL:   rsp_data = r_lo;
            OP_MULHU: rsp_data = r_hi;
            OP_DIVU:  rsp_data = r_lo;
            default:  rsp_data = r_rem;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_iter_seq.sv
// Directed and random bench for alu_iter_seq with an arithmetic reference model and a behavioural ALU.
module tb_alu_iter_seq;
   import alu_pkg::*;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [1:0]   req_op;
   logic [N-1:0] req_a;
   logic [N-1:0] req_b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [N-1:0] rsp_data;
   logic         alu_own;
   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic [4:0]   alu_op;
   logic [N-1:0] alu_c;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Stand-in for the parent's single-cycle ALU.
   assign alu_c = (alu_op == ALU_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);

   alu_iter_seq #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .alu_own   (alu_own),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_c     (alu_c)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] ref_result(input logic [1:0] op, input logic [N-1:0] a,
                                               input logic [N-1:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      case (op)
         2'd0:    return p[31:0];
         2'd1:    return p[63:32];
         2'd2:    return (b == 0) ? {N{1'b1}} : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef ALU_ITER_EARLY_OUT_EN
      if (op <= 2'd1 && (a == 0 || b == 0)) return 1;
      if (op >= 2'd2 && b != 0 && a < b) return 1;
`endif
      return N + 1;
   endfunction

   // Drive a request and leave the caller #1 after the accepting edge.
   task automatic issue(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input string tag);
      @(negedge clk);
      check({tag, "/req_ready"}, 64'(req_ready), 64'(1));
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic await_rsp(input logic [N-1:0] exp, input int exp_lat, input string tag);
      int lat;
      int own;
      lat = 1;
      own = 0;
      while (!rsp_valid && lat <= N + 4) begin
         if (alu_own) own++;
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "/own_cycles"}, 64'(own), 64'((exp_lat == 1) ? 0 : N));
      check({tag, "/data"}, 64'(rsp_data), 64'(exp));
      check({tag, "/own_in_done"}, 64'(alu_own), 64'(0));
   endtask

   task automatic take_rsp(input int stall, input logic [N-1:0] exp, input string tag);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         check({tag, "/stall_valid"}, 64'(rsp_valid), 64'(1));
         check({tag, "/stall_data"}, 64'(rsp_data), 64'(exp));
         check({tag, "/stall_ready"}, 64'(req_ready), 64'(0));
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check({tag, "/taken_valid"}, 64'(rsp_valid), 64'(0));
      check({tag, "/taken_ready"}, 64'(req_ready), 64'(1));
   endtask

   task automatic run_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input int stall, input string tag);
      logic [N-1:0] exp;
      exp = ref_result(op, a, b);
      issue(op, a, b, tag);
      await_rsp(exp, ref_lat(op, a, b), tag);
      take_rsp(stall, exp, tag);
   endtask

   initial begin
      logic [1:0]   op;
      logic [N-1:0] a;
      logic [N-1:0] b;

      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = 2'd0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset/rsp_valid", 64'(rsp_valid), 64'(0));
      check("reset/rsp_data", 64'(rsp_data), 64'(0));
      check("reset/alu_own", 64'(alu_own), 64'(0));
      check("reset/alu_a", 64'(alu_a), 64'(0));
      check("reset/alu_b", 64'(alu_b), 64'(0));
      check("reset/alu_op", 64'(alu_op), 64'(ALU_ADD));
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("reset/req_ready", 64'(req_ready), 64'(1));

      run_op(2'd0, 32'd7, 32'd6, 0, "mul_7x6");
      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_ones");
      run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_ones");
      run_op(2'd2, 32'd100, 32'd7, 0, "divu_100_7");
      run_op(2'd3, 32'd100, 32'd7, 0, "remu_100_7");
      run_op(2'd2, 32'h1234, 32'd0, 0, "divu_by0");
      run_op(2'd3, 32'h1234, 32'd0, 0, "remu_by0");
      run_op(2'd0, 32'd5, 32'd0, 0, "mul_5x0");
      run_op(2'd2, 32'd3, 32'd9, 0, "divu_3_9");
      run_op(2'd3, 32'd3, 32'd9, 0, "remu_3_9");

      // Held response with a competing request pending through the take edge.
      issue(2'd1, 32'h8000_0001, 32'h0000_0003, "hold");
      await_rsp(ref_result(2'd1, 32'h8000_0001, 32'h0000_0003),
                ref_lat(2'd1, 32'h8000_0001, 32'h0000_0003), "hold");
      req_valid = 1'b1;
      req_op    = 2'd0;
      req_a     = 32'd3;
      req_b     = 32'd3;
      take_rsp(5, ref_result(2'd1, 32'h8000_0001, 32'h0000_0003), "hold");
      check("hold/not_same_cycle", 64'(alu_own), 64'(0));
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("hold/next_accept_own", 64'(alu_own), 64'(1));
      check("hold/next_accept_ready", 64'(req_ready), 64'(0));
      await_rsp(32'd9, ref_lat(2'd0, 32'd3, 32'd3), "hold_next");
      take_rsp(0, 32'd9, "hold_next");

      // Reset in the middle of a divide.
      issue(2'd2, 32'd1000, 32'd3, "rst_mid");
      repeat (10) @(posedge clk);
      #1;
      check("rst_mid/busy", 64'(alu_own), 64'(1));
      rsp_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      rsp_ready = 1'b0;
      check("rst_mid/req_ready", 64'(req_ready), 64'(1));
      check("rst_mid/rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_mid/alu_own", 64'(alu_own), 64'(0));
      @(posedge clk);
      #1;
      check("rst_mid/still_idle", 64'(alu_own), 64'(0));
      run_op(2'd0, 32'd3, 32'd3, 0, "after_rst_mul");

      for (int k = 0; k < 24; k++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = 32'($urandom_range(1, 255));
            default: b = $urandom;
         endcase
         if (k % 6 == 5) a = '0;
         run_op(op, a, b, $urandom_range(0, 2), $sformatf("rand%0d_op%0d", k, op));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
